// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read side: default word width,
// stream word type and circular-pointer helper used by the local buffer.
package fifo_pkg;

    localparam int unsigned FIFO_BITS        = 32;
    localparam int unsigned STREAM_BUF_DEPTH = 3;

    typedef logic [FIFO_BITS-1:0] stream_word_t;
    typedef logic [1:0]           buf_ptr_t;

    // Three-entry pointer advance; any out-of-range value recovers to slot 0.
    function automatic buf_ptr_t ptr_next(input buf_ptr_t ptr);
        buf_ptr_t nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/stream_buf.sv
// Three-entry circular buffer: storage, read/write pointers and occupancy.
// Head word is presented combinationally so it lines up with occ != 0.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int BITS = FIFO_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    output logic [1:0]      occ,
    output logic [BITS-1:0] head_data
);

    logic [BITS-1:0] mem_r [0:2];
    buf_ptr_t        rd_ptr_r;
    buf_ptr_t        wr_ptr_r;
    logic [1:0]      occ_r;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves occ as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            occ_r    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Data storage needs no reset; a write during reset is harmless since occ stays 0.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign occ       = occ_r;
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_read_stream.sv
// Turns an async FIFO read port (request/empty, one-cycle read latency) into a
// valid/ready stream, using a three-entry buffer to absorb in-flight reads.
module fifo_read_stream
    import fifo_pkg::*;
#(
    parameter int BITS      = FIFO_BITS,
    parameter int BUF_DEPTH = STREAM_BUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    output logic            p_fifo_read_en,
    input  logic [BITS-1:0] p_fifo_read_data,
    input  logic            p_fifo_read_empty,
    output logic            p_out_valid,
    output logic [BITS-1:0] p_out_data,
    input  logic            p_out_ready,
    output logic [31:0]     p_out_count
);

    logic            inflight_r;
    logic [31:0]     count_r;
    logic [1:0]      occ_s;
    logic [BITS-1:0] head_data_s;
    logic [2:0]      pending_s;
    logic            read_en_s;
    logic            pop_s;

    // Read only while every buffered and in-flight word is guaranteed a slot;
    // deliberately independent of p_out_ready to keep the FIFO path short.
    always_comb begin
        pending_s = {1'b0, occ_s} + {2'b00, inflight_r};
        read_en_s = 1'b0;
        if (!p_fifo_read_empty && !rst && (pending_s < 3'(BUF_DEPTH))) begin
            read_en_s = 1'b1;
        end else begin
            read_en_s = 1'b0;
        end
        pop_s = (occ_s != 2'd0) && p_out_ready;
    end

    // Remember an issued read so its data is captured on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= read_en_s;
        end
    end

    // Transfer counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (pop_s) begin
            count_r <= count_r + 32'd1;
        end
    end

    stream_buf #(
        .BITS(BITS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (p_fifo_read_data),
        .pop       (pop_s),
        .occ       (occ_s),
        .head_data (head_data_s)
    );

    assign p_fifo_read_en = read_en_s;
    assign p_out_valid    = (occ_s != 2'd0);
    assign p_out_data     = head_data_s;
    assign p_out_count    = count_r;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a per-cycle vector table around reset, latency
// and backpressure, then hand-written streaming/sparse/mid-reset sequences.
module tb_fifo_read_stream;
    import fifo_pkg::*;

    logic         clk;
    logic         rst;
    logic         p_fifo_read_en;
    stream_word_t frdata;
    logic         p_fifo_read_empty;
    logic         p_out_valid;
    stream_word_t p_out_data;
    logic         p_out_ready;
    logic [31:0]  p_out_count;
    logic         force_empty;

    // Upstream FIFO model: words appended by the stimulus, read with one-cycle latency.
    stream_word_t fmem [0:255];
    int           fhead = 0;
    int           ftail = 0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rx_cnt   = 0;
    int first_rx = 0;
    int last_rx  = 0;
    int en_cnt   = 0;
    bit sb_en    = 1'b0;
    stream_word_t sb_q [$];

    fifo_read_stream dut (
        .clk               (clk),
        .rst               (rst),
        .p_fifo_read_en    (p_fifo_read_en),
        .p_fifo_read_data  (frdata),
        .p_fifo_read_empty (p_fifo_read_empty),
        .p_out_valid       (p_out_valid),
        .p_out_data        (p_out_data),
        .p_out_ready       (p_out_ready),
        .p_out_count       (p_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign p_fifo_read_empty = force_empty || (fhead == ftail);

    always @(posedge clk) begin
        if (p_fifo_read_en) begin
            frdata <= fmem[fhead[7:0]];
            fhead  <= fhead + 1;
        end
    end

    typedef struct {
        logic        rst;
        logic        empty_f;
        logic        ready;
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic [31:0] count;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] base, input int n, input bit to_sb);
        for (int i = 0; i < n; i++) begin
            fmem[ftail[7:0]] = base + 32'(i);
            if (to_sb) sb_q.push_back(base + 32'(i));
            ftail = ftail + 1;
        end
    endtask

    // One clock: scoreboard the transfer seen mid-cycle, then step past the edge.
    task automatic cycle();
        @(negedge clk);
        if (p_fifo_read_en) en_cnt++;
        if (sb_en && p_out_valid && p_out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual=0x%08h expected=none", p_out_data);
            end else begin
                chk("sb_order", p_out_data, sb_q.pop_front());
            end
            rx_cnt++;
            if (rx_cnt == 1) first_rx = cyc;
            last_rx = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input string name, input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 32'(rx_cnt), 32'(target));
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic start_sb();
        sb_q.delete();
        rx_cnt = 0;
        sb_en  = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        p_out_ready = 1'b1;
        force_empty = 1'b0;
        load(32'hA000_0001, 6, 1'b0);

        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          32'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0001, 32'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0001, 32'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0001, 32'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0001, 32'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0002, 32'd1};
        vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0003, 32'd2};
        vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0004, 32'd3};
        vt[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0005, 32'd4};
        vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0006, 32'd5};
        vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd6};
        vt[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd6};
        vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'd0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            rst         = vt[i].rst;
            force_empty = vt[i].empty_f;
            p_out_ready = vt[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d_read_en", i), 32'(p_fifo_read_en), 32'(vt[i].en));
            chk($sformatf("vec%0d_valid", i), 32'(p_out_valid), 32'(vt[i].valid));
            chk($sformatf("vec%0d_count", i), p_out_count, vt[i].count);
            if (vt[i].valid) chk($sformatf("vec%0d_data", i), p_out_data, vt[i].data);
            @(posedge clk);
            #1;
        end

        // Streaming 1..16 with the sink always ready.
        rst = 1'b1;
        start_sb();
        load(32'h0000_0001, 16, 1'b1);
        pulse_reset(2);
        p_out_ready = 1'b1;
        wait_rx("stream_done", 16, 60);
        chk("stream_back_to_back", 32'(last_rx - first_rx), 32'd15);
        chk("stream_count", p_out_count, 32'd16);
        chk("stream_drained_valid", 32'(p_out_valid), 32'd0);

        // Backpressure: sink stalled for 10 cycles with 8 words queued.
        rst         = 1'b1;
        p_out_ready = 1'b0;
        start_sb();
        load(32'h0000_0001, 8, 1'b1);
        pulse_reset(2);
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (p_out_valid) chk("bp_hold_data", p_out_data, 32'h0000_0001);
        end
        chk("bp_reads", 32'(en_cnt), 32'd3);
        chk("bp_read_en_off", 32'(p_fifo_read_en), 32'd0);
        chk("bp_valid", 32'(p_out_valid), 32'd1);
        chk("bp_count", p_out_count, 32'd0);
        p_out_ready = 1'b1;
        wait_rx("bp_done", 8, 40);
        chk("bp_final_count", p_out_count, 32'd8);

        // Sparse source with a random sink.
        rst = 1'b1;
        start_sb();
        load(32'h0000_0100, 20, 1'b1);
        pulse_reset(2);
        void'($urandom(7));
        begin
            int n = 0;
            while (rx_cnt < 20 && n < 400) begin
                force_empty = ((n / 2) % 2) == 1;
                p_out_ready = 1'($urandom_range(0, 1));
                cycle();
                n++;
            end
        end
        chk("sparse_done", 32'(rx_cnt), 32'd20);
        force_empty = 1'b0;
        p_out_ready = 1'b1;
        repeat (5) cycle();
        chk("sparse_count", p_out_count, 32'd20);
        chk("sparse_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset with a full buffer after 5 of 10 words.
        rst = 1'b1;
        start_sb();
        load(32'h0000_0201, 10, 1'b0);
        for (int i = 0; i < 5; i++) sb_q.push_back(32'h0000_0201 + 32'(i));
        pulse_reset(2);
        p_out_ready = 1'b1;
        wait_rx("mid_first5", 5, 40);
        p_out_ready = 1'b0;
        repeat (5) cycle();
        chk("mid_full_read_en", 32'(p_fifo_read_en), 32'd0);
        chk("mid_head", p_out_data, 32'h0000_0206);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_valid_after_rst", 32'(p_out_valid), 32'd0);
        chk("mid_count_after_rst", p_out_count, 32'd0);
        start_sb();
        sb_q.push_back(32'h0000_0209);
        sb_q.push_back(32'h0000_020A);
        p_out_ready = 1'b1;
        wait_rx("mid_fresh", 2, 40);
        repeat (5) cycle();
        chk("mid_fresh_count", p_out_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
